delayed_branch_resolver: RTL and testbench

// - Downstream partner of the branch-generation unit. It holds the delayed half of each split branch (dest + cond) while
//   the branch travels the pipeline, then evaluates cond against N/V/Z at the resolve point.
// - On a hit, flushes younger work and injects an absolute "goto dest" IR. It also drives p0/p1_do_delayed_B back to the

---
 rtl/kaiser_br_pkg.sv | 11 +
 rtl/br_cond_eval.sv | 22 ++
 rtl/delayed_branch_resolver.sv | 82 ++++++++
 tb/tb_delayed_branch_resolver.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/kaiser_br_pkg.sv
// kaiser_br_pkg: shared condition codes and delayed-branch record for the branch resolver
package kaiser_br_pkg;
  typedef enum logic [2:0] {NV, AL, EQ, NE, LT, LE, GT, GE} cond_t;
  localparam logic [7:0] B_ABS_PREFIX = 8'b001_00_000;
  typedef struct packed {
    logic       valid;
    logic       slot;
    cond_t      cond;
    logic [7:0] dest;
  } dbr_rec_t;
endpackage

// File: rtl/br_cond_eval.sv
// br_cond_eval: combinational branch-condition evaluation against N/V/Z flags
module br_cond_eval
  import kaiser_br_pkg::*;
(
  input  cond_t cond,
  input  logic  N,
  input  logic  V,
  input  logic  Z,
  output logic  take
);
  logic lt;
  always_comb begin
    lt = N ^ V;
    take = cond == AL ? 1'b1 :
           cond == EQ ? Z :
           cond == NE ? !Z :
           cond == LT ? lt :
           cond == LE ? lt | Z :
           cond == GT ? !lt & !Z :
           cond == GE ? !lt : 1'b0;
  end
endmodule

// File: rtl/delayed_branch_resolver.sv
// delayed_branch_resolver: queues delayed branch halves, resolves at head, flushes and injects goto-dest.
// Optional DBR_STATS_EN adds saturating stat_resolved/stat_hits counters.
module delayed_branch_resolver
  import kaiser_br_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PC_W  = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  input  logic            p0_is_b,
  input  logic            p1_is_b,
  input  logic [15:0]     p0_delayed_B_in,
  input  logic [2:0]      p0_delayed_cond,
  input  logic [15:0]     p1_delayed_B_in,
  input  logic [2:0]      p1_delayed_cond,
  input  logic            N,
  input  logic            V,
  input  logic            Z,
  output logic            flush,
  output logic            p0_do_delayed_B,
  output logic            p1_do_delayed_B,
  output logic [15:0]     inject_IR,
  output logic [PC_W-1:0] redirect_pc
`ifdef DBR_STATS_EN
  ,
  output logic [15:0]     stat_resolved,
  output logic [15:0]     stat_hits
`endif
);
  localparam logic [1:0] S_IDLE = 2'd0, S_HIT = 2'd1, S_INJECT = 2'd2;
  logic [1:0] state;
  dbr_rec_t q [DEPTH];
  dbr_rec_t head, cap;
  logic take, eval, hit, slot_r;
  logic [7:0] dest_r;
  assign head = q[DEPTH-1];
  br_cond_eval u_eval (.cond(head.cond), .N(N), .V(V), .Z(Z), .take(take));
  // p1 is dead whenever p0 branches, so p0 has priority
  always_comb begin
    cap = p0_is_b ? dbr_rec_t'{1'b1, 1'b0, cond_t'(p0_delayed_cond), p0_delayed_B_in[7:0]} :
          p1_is_b ? dbr_rec_t'{1'b1, 1'b1, cond_t'(p1_delayed_cond), p1_delayed_B_in[7:0]} : '0;
    eval = state == S_IDLE && advance && head.valid;
    hit = eval && take;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      slot_r <= 1'b0;
      dest_r <= '0;
    end else begin
      if (hit || state != S_IDLE) for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      else if (advance) begin
        q[0] <= cap;
        for (int i = 1; i < DEPTH; i++) q[i] <= q[i-1];
      end
      if (hit) begin
        slot_r <= head.slot;
        dest_r <= head.dest;
      end
      state <= hit ? S_HIT :
               state == S_HIT ? S_INJECT :
               state == S_INJECT && advance ? S_IDLE : state;
    end
  assign flush = state == S_HIT;
  assign p0_do_delayed_B = state == S_INJECT && !slot_r;
  assign p1_do_delayed_B = state == S_INJECT && slot_r;
  assign inject_IR = state == S_INJECT ? {B_ABS_PREFIX, dest_r} : '0;
  assign redirect_pc = state == S_INJECT ? PC_W'({dest_r[7:1], 1'b0}) : '0;
`ifdef DBR_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_resolved <= '0;
      stat_hits <= '0;
    end else begin
      if (eval && !(&stat_resolved)) stat_resolved <= stat_resolved + 16'd1;
      if (hit && !(&stat_hits)) stat_hits <= stat_hits + 16'd1;
    end
`endif
endmodule

// File: tb/tb_delayed_branch_resolver.sv
// tb_delayed_branch_resolver: directed + random stimulus, index-based reference model, scoreboard monitor
module tb_delayed_branch_resolver;
  localparam int DEPTH = 2;
  localparam int PC_W = 9;
  localparam bit [2:0] C_NV = 0, C_AL = 1, C_EQ = 2, C_LT = 4;
  logic clk = 0, rst_n = 0, advance = 0, p0_is_b = 0, p1_is_b = 0, N = 0, V = 0, Z = 0;
  logic [15:0] p0_delayed_B_in = 0, p1_delayed_B_in = 0;
  logic [2:0] p0_delayed_cond = 0, p1_delayed_cond = 0;
  logic flush, p0_do_delayed_B, p1_do_delayed_B;
  logic [15:0] inject_IR;
  logic [PC_W-1:0] redirect_pc;
`ifdef DBR_STATS_EN
  logic [15:0] stat_resolved, stat_hits;
`endif
  int checks = 0, errors = 0;

  delayed_branch_resolver #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .advance(advance), .p0_is_b(p0_is_b), .p1_is_b(p1_is_b),
    .p0_delayed_B_in(p0_delayed_B_in), .p0_delayed_cond(p0_delayed_cond),
    .p1_delayed_B_in(p1_delayed_B_in), .p1_delayed_cond(p1_delayed_cond),
    .N(N), .V(V), .Z(Z), .flush(flush), .p0_do_delayed_B(p0_do_delayed_B),
    .p1_do_delayed_B(p1_do_delayed_B), .inject_IR(inject_IR), .redirect_pc(redirect_pc)
`ifdef DBR_STATS_EN
    , .stat_resolved(stat_resolved), .stat_hits(stat_hits)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a record captured at idle advance k is judged at idle advance k+DEPTH
  typedef struct {int idx; bit slot; bit [2:0] cond; bit [7:0] dest;} mrec_t;
  typedef struct {bit slot; bit [7:0] dest;} exp_t;
  mrec_t pend[$];
  exp_t sb[$];
  int mode = 0, adv_k = 0;

  function automatic bit ref_take(bit [2:0] c, bit n, bit v, bit z);
    bit less;
    less = (n != v);
    case (c)
      0: return 1'b0;
      1: return 1'b1;
      2: return z;
      3: return !z;
      4: return less;
      5: return less || z;
      6: return !less && !z;
      default: return !less;
    endcase
  endfunction

  task automatic model();
    mrec_t r;
    bit hit;
    if (mode == 1) mode = 2;
    else if (mode == 2) begin
      if (advance) mode = 0;
    end else if (advance) begin
      adv_k++;
      hit = 0;
      if (pend.size() > 0 && pend[0].idx == adv_k - DEPTH) begin
        r = pend.pop_front();
        if (ref_take(r.cond, N, V, Z)) begin
          hit = 1;
          sb.push_back('{r.slot, r.dest});
          pend.delete();
          mode = 1;
        end
      end
      if (!hit && (p0_is_b || p1_is_b))
        pend.push_back('{adv_k, !p0_is_b, p0_is_b ? p0_delayed_cond : p1_delayed_cond,
                         p0_is_b ? p0_delayed_B_in[7:0] : p1_delayed_B_in[7:0]});
    end
  endtask

  task automatic step(bit a, bit b0, bit b1, bit [2:0] c0, bit [7:0] d0, bit [2:0] c1, bit [7:0] d1,
                      bit [2:0] nvz);
    advance = a; p0_is_b = b0; p1_is_b = b1;
    p0_delayed_cond = c0; p0_delayed_B_in = {8'h20, d0};
    p1_delayed_cond = c1; p1_delayed_B_in = {8'h20, d1};
    N = nvz[2]; V = nvz[1]; Z = nvz[0];
    @(posedge clk);
    model();
    #1;
  endtask

  task automatic idle(bit a, bit [2:0] nvz);
    step(a, 0, 0, C_NV, 8'h00, C_NV, 8'h00, nvz);
  endtask

  // Monitor: st 0 idle, 1 flush seen, 2 injecting
  exp_t cur;
  int st = 0;
  always @(negedge clk) begin
    if (!rst_n) st = 0;
    else if (flush) begin
      chk("flush_expected", sb.size() > 0, 1);
      if (sb.size() > 0) cur = sb.pop_front();
      chk("no_inject_during_flush", {p0_do_delayed_B, p1_do_delayed_B}, 0);
      st = 1;
    end else if (st != 0) begin
      chk("p0_do", p0_do_delayed_B, !cur.slot);
      chk("p1_do", p1_do_delayed_B, cur.slot);
      chk("inject_IR", inject_IR, 16'h2000 | cur.dest);
      chk("redirect_pc", redirect_pc, cur.dest & 8'hFE);
      st = advance ? 0 : 2;
    end else chk("idle_no_inject", {p0_do_delayed_B, p1_do_delayed_B}, 0);
  end

  initial begin
    #3;
    chk("rst_flush", flush, 0);
    chk("rst_do", {p0_do_delayed_B, p1_do_delayed_B}, 0);
    chk("rst_inject_IR", inject_IR, 0);
    chk("rst_redirect", redirect_pc, 0);
    #3 rst_n = 1;
    // p0 EQ hit on Z
    step(1, 1, 0, C_EQ, 8'h24, C_NV, 8'h00, 3'b000);
    idle(1, 3'b000);
    idle(1, 3'b001);
    idle(0, 0); idle(0, 0); idle(1, 0); idle(1, 0);
    // p1 LT with N=V: retired silently
    step(1, 0, 1, C_NV, 8'h00, C_LT, 8'h33, 3'b000);
    idle(1, 3'b000); idle(1, 3'b000); idle(1, 3'b000); idle(1, 3'b110);
    // younger AL record behind a hit is cleared
    step(1, 1, 0, C_AL, 8'h40, C_NV, 8'h00, 0);
    step(1, 0, 1, C_NV, 8'h00, C_AL, 8'h50, 0);
    idle(1, 0); idle(1, 0); idle(1, 0); idle(1, 0); idle(1, 0); idle(1, 0);
    // hit then 5-cycle stall in INJECT
    step(1, 1, 0, C_AL, 8'h5A, C_NV, 8'h00, 0);
    idle(1, 0); idle(1, 0); idle(0, 0);
    repeat (5) idle(0, 0);
    idle(1, 0); idle(1, 0);
    // odd dest, slot 1
    step(1, 0, 1, C_NV, 8'h00, C_AL, 8'h11, 0);
    idle(1, 0); idle(1, 0); idle(0, 0); idle(0, 0); idle(1, 0); idle(1, 0);
    // async reset in the middle of INJECT
    step(1, 1, 0, C_AL, 8'h77, C_NV, 8'h00, 0);
    idle(1, 0); idle(1, 0); idle(0, 0); idle(0, 0);
    #2 rst_n = 0;
    #1;
    chk("midrst_flush", flush, 0);
    chk("midrst_do", {p0_do_delayed_B, p1_do_delayed_B}, 0);
    chk("midrst_inject_IR", inject_IR, 0);
    chk("midrst_redirect", redirect_pc, 0);
`ifdef DBR_STATS_EN
    chk("midrst_stats", {stat_resolved, stat_hits}, 0);
`endif
    mode = 0; adv_k = 0; pend.delete(); sb.delete();
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           3'($urandom), 8'($urandom), 3'($urandom), 8'($urandom), 3'($urandom));
    repeat (12) idle(1, 0);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
